// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and its write-side buffer.
package reg_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  // R0 is hard-wired to zero, so writes to it are never buffered.
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/reg_wb_lookup.sv
// Youngest-match bypass search over the pending writes of reg_write_buffer.
// The entry vectors are ordered oldest (index 0) to youngest (index DEPTH-1).
// The output stage is older than every FIFO entry.
module reg_wb_lookup
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic [ADDR_WIDTH-1:0]       lookup_addr,
  input  logic [DEPTH-1:0]            ent_vld,
  input  logic [DEPTH*ADDR_WIDTH-1:0] ent_addr,
  input  logic [DEPTH*DATA_WIDTH-1:0] ent_data,
  input  logic                        out_vld,
  input  logic [ADDR_WIDTH-1:0]       out_addr,
  input  logic [DATA_WIDTH-1:0]       out_data,
  output logic                        hit,
  output logic [DATA_WIDTH-1:0]       data
);

  // Scan from oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (lookup_addr != ADDR_WIDTH'(REG_ZERO)) begin
      if (out_vld && (out_addr == lookup_addr)) begin
        hit  = 1'b1;
        data = out_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && (ent_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == lookup_addr)) begin
          hit  = 1'b1;
          data = ent_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/reg_write_buffer.sv
// Write-back buffer in front of the register file: a DEPTH-entry FIFO drains
// one request per cycle into a registered write port. Two lookup ports expose
// pending writes so readers can bypass not-yet-committed data.
module reg_write_buffer
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Wr_Valid_i,
  output logic                    Wr_Ready_o,
  input  logic [ADDR_WIDTH-1:0]   Wr_Addr_i,
  input  logic [DATA_WIDTH-1:0]   Wr_Data_i,
  input  logic                    Stall_i,
  output logic                    Reg_Write_o,
  output logic [ADDR_WIDTH-1:0]   Write_Register_o,
  output logic [DATA_WIDTH-1:0]   Write_Data_o,
  input  logic [ADDR_WIDTH-1:0]   Lookup_Addr_1_i,
  output logic                    Lookup_Hit_1_o,
  output logic [DATA_WIDTH-1:0]   Lookup_Data_1_o,
  input  logic [ADDR_WIDTH-1:0]   Lookup_Addr_2_i,
  output logic                    Lookup_Hit_2_o,
  output logic [DATA_WIDTH-1:0]   Lookup_Data_2_o,
  output logic [$clog2(DEPTH):0]  Count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0]       mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0]       mem_data [DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            count;
  logic                        push;
  logic                        pop;
  logic [DEPTH-1:0]            ent_vld;
  logic [DEPTH*ADDR_WIDTH-1:0] ent_addr;
  logic [DEPTH*DATA_WIDTH-1:0] ent_data;

  // Full buffer refuses new requests even if it drains this edge (no pass-through).
  assign Wr_Ready_o = (count != CNT_W'(DEPTH));
  assign push       = Wr_Valid_i & Wr_Ready_o & (Wr_Addr_i != ADDR_WIDTH'(REG_ZERO));
  assign pop        = (count != '0) & ~Stall_i;
  assign Count_o    = count;

  // FIFO storage: data-only, contents are meaningless while count excludes them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= Wr_Addr_i;
      mem_data[wr_ptr] <= Wr_Data_i;
    end
  end

  // Pointers, occupancy and the registered register-file write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      Reg_Write_o      <= 1'b0;
      Write_Register_o <= '0;
      Write_Data_o     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      Reg_Write_o <= pop;
      if (pop) begin
        Write_Register_o <= mem_addr[rd_ptr];
        Write_Data_o     <= mem_data[rd_ptr];
      end
    end
  end

  // Present the occupied FIFO slots to the lookups in age order, oldest first.
  always_comb begin
    ent_vld  = '0;
    ent_addr = '0;
    ent_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]                             = (CNT_W'(i) < count);
      ent_addr[i*ADDR_WIDTH +: ADDR_WIDTH]   = mem_addr[rd_ptr + PTR_W'(i)];
      ent_data[i*DATA_WIDTH +: DATA_WIDTH]   = mem_data[rd_ptr + PTR_W'(i)];
    end
  end

  reg_wb_lookup #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_lookup_1 (
    .lookup_addr (Lookup_Addr_1_i),
    .ent_vld     (ent_vld),
    .ent_addr    (ent_addr),
    .ent_data    (ent_data),
    .out_vld     (Reg_Write_o),
    .out_addr    (Write_Register_o),
    .out_data    (Write_Data_o),
    .hit         (Lookup_Hit_1_o),
    .data        (Lookup_Data_1_o)
  );

  reg_wb_lookup #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_lookup_2 (
    .lookup_addr (Lookup_Addr_2_i),
    .ent_vld     (ent_vld),
    .ent_addr    (ent_addr),
    .ent_data    (ent_data),
    .out_vld     (Reg_Write_o),
    .out_addr    (Write_Register_o),
    .out_data    (Write_Data_o),
    .hit         (Lookup_Hit_2_o),
    .data        (Lookup_Data_2_o)
  );

endmodule

// File: tb/tb_reg_write_buffer.sv
// Directed bench for reg_write_buffer with a behavioural register file downstream.
module tb_reg_write_buffer;
  import reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Wr_Valid_i;
  logic        Wr_Ready_o;
  logic [4:0]  Wr_Addr_i;
  logic [31:0] Wr_Data_i;
  logic        Stall_i;
  logic        Reg_Write_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Write_Data_o;
  logic [4:0]  Lookup_Addr_1_i;
  logic        Lookup_Hit_1_o;
  logic [31:0] Lookup_Data_1_o;
  logic [4:0]  Lookup_Addr_2_i;
  logic        Lookup_Hit_2_o;
  logic [31:0] Lookup_Data_2_o;
  logic [2:0]  Count_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rf [NUM_REGS] = '{default: '0};

  always #5 clk = ~clk;

  reg_write_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .Wr_Valid_i       (Wr_Valid_i),
    .Wr_Ready_o       (Wr_Ready_o),
    .Wr_Addr_i        (Wr_Addr_i),
    .Wr_Data_i        (Wr_Data_i),
    .Stall_i          (Stall_i),
    .Reg_Write_o      (Reg_Write_o),
    .Write_Register_o (Write_Register_o),
    .Write_Data_o     (Write_Data_o),
    .Lookup_Addr_1_i  (Lookup_Addr_1_i),
    .Lookup_Hit_1_o   (Lookup_Hit_1_o),
    .Lookup_Data_1_o  (Lookup_Data_1_o),
    .Lookup_Addr_2_i  (Lookup_Addr_2_i),
    .Lookup_Hit_2_o   (Lookup_Hit_2_o),
    .Lookup_Data_2_o  (Lookup_Data_2_o),
    .Count_o          (Count_o)
  );

  // Downstream register file: commits at the edge where Reg_Write_o is high.
  always @(posedge clk) begin
    if (Reg_Write_o && (Write_Register_o != REG_ZERO))
      rf[Write_Register_o] <= Write_Data_o;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input wr_req_t req);
    Wr_Valid_i = 1'b1;
    Wr_Addr_i  = req.addr;
    Wr_Data_i  = req.data;
    tick();
    Wr_Valid_i = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [4:0] a,
                           input logic [31:0] d, input int cnt);
    check_val({tag, "_rw"},  64'(Reg_Write_o), 64'(vld));
    if (vld) begin
      check_val({tag, "_reg"}, 64'(Write_Register_o), 64'(a));
      check_val({tag, "_dat"}, 64'(Write_Data_o), 64'(d));
    end
    check_val({tag, "_cnt"}, 64'(Count_o), 64'(cnt));
  endtask

  wr_req_t fill4 [4];
  wr_req_t fill5 [4];
  wr_req_t fill6 [3];

  initial begin
    fill4 = '{'{5'd4, 32'd20}, '{5'd25, 32'd6}, '{5'd31, 32'd78}, '{5'd4, 32'd99}};
    fill5 = '{'{5'd1, 32'd11}, '{5'd3, 32'd13}, '{5'd5, 32'd15}, '{5'd7, 32'd17}};
    fill6 = '{'{5'd10, 32'd1}, '{5'd11, 32'd2}, '{5'd12, 32'd3}};

    reset = 1'b0; Wr_Valid_i = 1'b0; Wr_Addr_i = '0; Wr_Data_i = '0; Stall_i = 1'b0;
    Lookup_Addr_1_i = 5'd2; Lookup_Addr_2_i = 5'd4;

    // 1: reset
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_val("rst_rw",    64'(Reg_Write_o), 64'(0));
    check_val("rst_cnt",   64'(Count_o), 64'(0));
    check_val("rst_rdy",   64'(Wr_Ready_o), 64'(1));
    check_val("rst_hit1",  64'(Lookup_Hit_1_o), 64'(0));
    check_val("rst_hit2",  64'(Lookup_Hit_2_o), 64'(0));
    check_val("rst_reg",   64'(Write_Register_o), 64'(0));

    // 2: single write, addr 2 data 7
    push_seq('{5'd2, 32'd7});
    check_out("w1_k", 1'b0, 5'd0, 32'd0, 1);
    check_val("w1_k_hit",  64'(Lookup_Hit_1_o), 64'(1));
    check_val("w1_k_data", 64'(Lookup_Data_1_o), 64'(7));
    tick();
    check_out("w1_k1", 1'b1, 5'd2, 32'd7, 0);
    check_val("w1_k1_hit",  64'(Lookup_Hit_1_o), 64'(1));
    check_val("w1_k1_data", 64'(Lookup_Data_1_o), 64'(7));
    tick();
    check_out("w1_k2", 1'b0, 5'd0, 32'd0, 0);
    check_val("w1_k2_hit", 64'(Lookup_Hit_1_o), 64'(0));
    check_val("w1_rf2",    64'(rf[2]), 64'(7));

    // 3: write to R0 is accepted but dropped
    Lookup_Addr_1_i = 5'd0;
    Wr_Valid_i = 1'b1; Wr_Addr_i = 5'd0; Wr_Data_i = 32'd3;
    #1;
    check_val("r0_rdy", 64'(Wr_Ready_o), 64'(1));
    tick();
    Wr_Valid_i = 1'b0;
    check_out("r0_a", 1'b0, 5'd0, 32'd0, 0);
    check_val("r0_hit", 64'(Lookup_Hit_1_o), 64'(0));
    tick();
    check_out("r0_b", 1'b0, 5'd0, 32'd0, 0);
    check_val("r0_rf0", 64'(rf[0]), 64'(0));

    // 4: fill under stall, youngest lookup, ordered drain
    Stall_i = 1'b1;
    Lookup_Addr_1_i = 5'd4; Lookup_Addr_2_i = 5'd25;
    for (int i = 0; i < 4; i++) push_seq(fill4[i]);
    check_out("fill_full", 1'b0, 5'd0, 32'd0, 4);
    check_val("fill_rdy",   64'(Wr_Ready_o), 64'(0));
    check_val("fill_hit1",  64'(Lookup_Hit_1_o), 64'(1));
    check_val("fill_data1", 64'(Lookup_Data_1_o), 64'(99));
    check_val("fill_hit2",  64'(Lookup_Hit_2_o), 64'(1));
    check_val("fill_data2", 64'(Lookup_Data_2_o), 64'(6));
    tick();
    check_out("fill_hold", 1'b0, 5'd0, 32'd0, 4);
    Stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("drain", 1'b1, fill4[i].addr, fill4[i].data, 3 - i);
      if (i == 0) check_val("drain_young", 64'(Lookup_Data_1_o), 64'(99));
    end
    tick();
    check_out("drain_end", 1'b0, 5'd0, 32'd0, 0);
    check_val("rf4",  64'(rf[4]),  64'(99));
    check_val("rf25", 64'(rf[25]), 64'(6));
    check_val("rf31", 64'(rf[31]), 64'(78));

    // 5: push offered while full, then push and pop together
    Stall_i = 1'b1;
    for (int i = 0; i < 4; i++) push_seq(fill5[i]);
    Stall_i = 1'b0;
    Wr_Valid_i = 1'b1; Wr_Addr_i = 5'd9; Wr_Data_i = 32'd19;
    #1;
    check_val("full_rdy", 64'(Wr_Ready_o), 64'(0));
    tick();
    check_out("full_pop", 1'b1, 5'd1, 32'd11, 3);
    tick();
    Wr_Valid_i = 1'b0;
    check_out("pushpop", 1'b1, 5'd3, 32'd13, 3);
    tick();
    check_out("pp_d5", 1'b1, 5'd5, 32'd15, 2);
    tick();
    check_out("pp_d7", 1'b1, 5'd7, 32'd17, 1);
    tick();
    check_out("pp_d9", 1'b1, 5'd9, 32'd19, 0);
    tick();
    check_out("pp_end", 1'b0, 5'd0, 32'd0, 0);
    check_val("rf9", 64'(rf[9]), 64'(19));

    // 6: reset asserted mid-drain
    Stall_i = 1'b1;
    Lookup_Addr_1_i = 5'd11; Lookup_Addr_2_i = 5'd12;
    for (int i = 0; i < 3; i++) push_seq(fill6[i]);
    Stall_i = 1'b0;
    tick();
    check_out("md_pop", 1'b1, 5'd10, 32'd1, 2);
    reset = 1'b0;
    #1;
    check_out("md_rst", 1'b0, 5'd0, 32'd0, 0);
    check_val("md_reg",  64'(Write_Register_o), 64'(0));
    check_val("md_hit1", 64'(Lookup_Hit_1_o), 64'(0));
    check_val("md_hit2", 64'(Lookup_Hit_2_o), 64'(0));
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("md_idle", 1'b0, 5'd0, 32'd0, 0);
    end
    check_val("md_rf10", 64'(rf[10]), 64'(0));
    check_val("md_rf11", 64'(rf[11]), 64'(0));
    check_val("md_rf12", 64'(rf[12]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
